sorted_stream_unloader: RTL and testbench

Downstream stage of `bitonic_recursive_top`: captures each sorted block presented on the sorter's flat `y` bus with its `y_valid` pulse and streams it out one word per cycle over a valid/ready interface. A two-bank ping-pong buffer absorbs one further block while the previous block drains, so the sorter, which has no backpressure input, can run back-to-back. Blocks that arrive when both banks are occupied are dropped and flagged.

---
 rtl/sorted_stream_unloader.sv | 73 +++++++
 tb/tb_sorted_stream_unloader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_stream_unloader.sv
// sorted_stream_unloader: ping-pong buffer that streams each sorted block out one word per cycle
module sorted_stream_unloader #(
    parameter int LOG_INPUT  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]   in_data,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic [LOG_INPUT-1:0]                   out_index,
    output logic                                   busy,
    output logic                                   overflow
);
    localparam int N = 2**LOG_INPUT;

    logic [DATA_WIDTH*N-1:0] bank [2];
    logic [1:0]              full;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [LOG_INPUT-1:0]    cnt;
    logic                    ovf;
    logic                    xfer;
    logic                    freeing;
    logic                    accept;
    logic                    cap;
    logic                    drop;

    assign out_valid = full[rd_sel];
    assign out_data  = bank[rd_sel][DATA_WIDTH*int'(cnt) +: DATA_WIDTH];
    assign out_index = cnt;
    assign out_last  = out_valid & (&cnt);
    assign busy      = |full;
    assign overflow  = ovf;

    assign xfer    = out_valid & out_ready;
    assign freeing = xfer & (&cnt);
    // a full write bank still accepts when its last word leaves this very cycle
    assign accept  = !full[wr_sel] | (freeing & (rd_sel == wr_sel));
    assign cap     = in_valid & accept;
    assign drop    = in_valid & !accept;

    always_ff @(posedge clk) begin
        if (cap)
            bank[wr_sel] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (xfer)
                cnt <= cnt + 1'b1;
            if (freeing) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
            if (cap) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (drop)
                ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sorted_stream_unloader.sv
// tb_sorted_stream_unloader: table, directed and randomized checks against a block-queue model
module tb_sorted_stream_unloader;
    logic        clk = 1'b0;
    logic        rst, iv, ordy;
    logic [31:0] idata;
    logic [7:0]  od;
    logic        ov, ol, ob, oo;
    logic [1:0]  oi;

    logic         rst5, iv5, ordy5;
    logic [1023:0] id5;
    logic [31:0]  od5;
    logic         ov5, ol5, ob5, oo5;
    logic [4:0]   oi5;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sorted_stream_unloader #(.LOG_INPUT(2), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_data(idata), .out_data(od), .out_valid(ov),
        .out_ready(ordy), .out_last(ol), .out_index(oi), .busy(ob), .overflow(oo)
    );

    sorted_stream_unloader #(.LOG_INPUT(5), .DATA_WIDTH(32)) dut5 (
        .clk(clk), .rst(rst5), .in_valid(iv5), .in_data(id5), .out_data(od5), .out_valid(ov5),
        .out_ready(ordy5), .out_last(ol5), .out_index(oi5), .busy(ob5), .overflow(oo5)
    );

    // reference model: a queue of at most two pending blocks plus the read position in the head block
    logic [31:0] mq[$];
    int          midx;
    bit          movf;
    logic [7:0]  olog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [31:0] d, input bit rdy);
        bit xfer;
        if (r) begin
            mq.delete();
            midx = 0;
            movf = 0;
            return;
        end
        xfer = mq.size() > 0 && rdy;
        if (xfer) begin
            if (midx == 3) begin
                void'(mq.pop_front());
                midx = 0;
            end else
                midx++;
        end
        if (v) begin
            if (mq.size() < 2)
                mq.push_back(d);
            else
                movf = 1;
        end
    endtask

    task automatic tick(input bit r, input bit v, input logic [31:0] d, input bit rdy);
        rst = r; iv = v; idata = d; ordy = rdy;
        #1;
        if (ov && ordy && !r)
            olog.push_back(od);
        model_edge(r, v, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string nm);
        logic [31:0] blk;
        bit          v;
        v = mq.size() > 0;
        chk({nm, ".valid"}, ov, v);
        if (v) begin
            blk = mq[0];
            chk({nm, ".data"}, od, blk[8*midx +: 8]);
        end
        chk({nm, ".index"}, oi, midx);
        chk({nm, ".last"}, ol, v && midx == 3);
        chk({nm, ".busy"}, ob, v);
        chk({nm, ".overflow"}, oo, movf);
    endtask

    typedef struct {
        bit          r, v;
        logic [31:0] d;
        bit          rdy;
        bit          ev, edv;
        logic [7:0]  eod;
        logic [1:0]  eoi;
        bit          eol, eob, eoo;
    } vec_t;

    localparam logic [31:0] BLK = 32'h40302010;
    vec_t tbl[17];

    initial begin
        logic [31:0] abc[3];
        logic [31:0] w5[32];
        logic [31:0] prev;
        logic [31:0] tmp;

        rst = 1; iv = 0; idata = 0; ordy = 0;
        rst5 = 1; iv5 = 0; id5 = '0; ordy5 = 0;

        tbl[0]  = '{1, 1, BLK, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[1]  = '{1, 1, BLK, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[2]  = '{0, 1, BLK, 1, 1, 1, 8'h10, 2'd0, 0, 1, 0};
        tbl[3]  = '{0, 0, 0,   1, 1, 1, 8'h20, 2'd1, 0, 1, 0};
        tbl[4]  = '{0, 0, 0,   1, 1, 1, 8'h30, 2'd2, 0, 1, 0};
        tbl[5]  = '{0, 0, 0,   1, 1, 1, 8'h40, 2'd3, 1, 1, 0};
        tbl[6]  = '{0, 0, 0,   1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,   1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[8]  = '{0, 1, BLK, 0, 1, 1, 8'h10, 2'd0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0,   1, 1, 1, 8'h20, 2'd1, 0, 1, 0};
        tbl[10] = '{0, 0, 0,   0, 1, 1, 8'h20, 2'd1, 0, 1, 0};
        tbl[11] = '{0, 0, 0,   0, 1, 1, 8'h20, 2'd1, 0, 1, 0};
        tbl[12] = '{0, 0, 0,   1, 1, 1, 8'h30, 2'd2, 0, 1, 0};
        tbl[13] = '{0, 0, 0,   0, 1, 1, 8'h30, 2'd2, 0, 1, 0};
        tbl[14] = '{0, 0, 0,   1, 1, 1, 8'h40, 2'd3, 1, 1, 0};
        tbl[15] = '{0, 0, 0,   0, 1, 1, 8'h40, 2'd3, 1, 1, 0};
        tbl[16] = '{0, 0, 0,   1, 0, 0, 8'h00, 2'd0, 0, 0, 0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d.valid", i), ov, tbl[i].ev);
            if (tbl[i].edv)
                chk($sformatf("tbl%0d.data", i), od, tbl[i].eod);
            chk($sformatf("tbl%0d.index", i), oi, tbl[i].eoi);
            chk($sformatf("tbl%0d.last", i), ol, tbl[i].eol);
            chk($sformatf("tbl%0d.busy", i), ob, tbl[i].eob);
            chk($sformatf("tbl%0d.overflow", i), oo, tbl[i].eoo);
        end

        // ping-pong with a third block dropped
        abc[0] = 32'h04030201; abc[1] = 32'h14131211; abc[2] = 32'h24232221;
        tick(1, 0, 0, 1);
        olog.delete();
        tick(0, 1, abc[0], 1); cmp_model("pp0");
        tick(0, 1, abc[1], 1); cmp_model("pp1");
        tick(0, 1, abc[2], 1); cmp_model("pp2");
        chk("pp.overflow_set", oo, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 1);
            cmp_model($sformatf("pp%0d", i + 3));
        end
        chk("pp.count", olog.size(), 8);
        for (int i = 0; i < 8 && i < olog.size(); i++) begin
            tmp = abc[i/4];
            chk($sformatf("pp.word%0d", i), olog[i], tmp[8*(i%4) +: 8]);
        end
        chk("pp.overflow_sticky", oo, 1);

        // third block lands in the bank freed on the same edge
        tick(1, 0, 0, 1);
        olog.delete();
        tick(0, 1, abc[0], 1);
        tick(0, 1, abc[1], 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 1, abc[2], 1); cmp_model("ff.c");
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 1);
            cmp_model($sformatf("ff%0d", i));
        end
        chk("ff.count", olog.size(), 12);
        for (int i = 0; i < 12 && i < olog.size(); i++) begin
            tmp = abc[i/4];
            chk($sformatf("ff.word%0d", i), olog[i], tmp[8*(i%4) +: 8]);
        end
        chk("ff.overflow", oo, 0);

        // randomized traffic against the model
        tick(1, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
            cmp_model($sformatf("rnd%0d", i));
        end

        // default size: one ascending 32-word block, then reset mid-stream
        prev = $urandom_range(0, 1000);
        for (int i = 0; i < 32; i++) begin
            prev = prev + $urandom_range(0, 5);
            w5[i] = prev;
            id5[32*i +: 32] = prev;
        end
        rst5 = 1; ordy5 = 1;
        @(posedge clk); #1;
        rst5 = 0; iv5 = 1;
        @(posedge clk); #1;
        iv5 = 0;
        prev = 0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("big%0d.valid", k), ov5, 1);
            chk($sformatf("big%0d.data", k), od5, w5[k]);
            chk($sformatf("big%0d.order", k), od5 >= prev, 1);
            chk($sformatf("big%0d.index", k), oi5, k);
            chk($sformatf("big%0d.last", k), ol5, k == 31);
            prev = od5;
            @(posedge clk); #1;
        end
        chk("big.done_valid", ov5, 0);
        chk("big.done_busy", ob5, 0);
        chk("big.overflow", oo5, 0);
        iv5 = 1;
        @(posedge clk); #1;
        iv5 = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        chk("big.mid_index", oi5, 10);
        chk("big.mid_data", od5, w5[10]);
        rst5 = 1;
        @(posedge clk); #1;
        rst5 = 0;
        chk("big.rst_valid", ov5, 0);
        chk("big.rst_busy", ob5, 0);
        chk("big.rst_index", oi5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
